// File: rtl/ifetch_pkg.sv
// Purpose: shared defaults, state encoding and queue entry layout for the fetch sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ifetch_pkg;

   localparam int          IF_AW       = 16;
   localparam int          IF_DW       = 16;
   localparam logic [15:0] IF_RESET_PC = 16'h0000;
   localparam logic [3:0]  IF_HLT_OP   = 4'hF;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   // One prefetched word tagged with the address it came from.
   typedef struct packed {
      logic [IF_AW-1:0] pc;
      logic [IF_DW-1:0] instr;
   } entry_t;

endpackage

// File: rtl/ifetch_if.sv
// Purpose: instruction-memory bus plus decode valid/ready and redirect signals.
// Latency: n/a (wiring only).
// Backpressure: instr_rdy from decode; master = fetch controller, slave = memory/decode side.
interface ifetch_if
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = IF_AW,
   parameter int DW    = IF_DW
);

   logic [AW-1:0]            im_addr;
   logic                     im_rd_en;
   logic [DW-1:0]            im_instr;
   logic [DW-1:0]            instr_out;
   logic [AW-1:0]            instr_pc;
   logic                     instr_vld;
   logic                     instr_rdy;
   logic                     redirect;
   logic [AW-1:0]            redirect_pc;
   logic                     halted;
   logic [$clog2(DEPTH):0]   q_count;

   modport master (
      output im_addr, im_rd_en, instr_out, instr_pc, instr_vld, halted, q_count,
      input  im_instr, instr_rdy, redirect, redirect_pc
   );

   modport slave (
      input  im_addr, im_rd_en, instr_out, instr_pc, instr_vld, halted, q_count,
      output im_instr, instr_rdy, redirect, redirect_pc
   );

endinterface

// File: rtl/ifetch_fifo.sv
// Purpose: generic synchronous FIFO with flush; head is the oldest entry, shown combinationally.
// Latency: a push is visible at head the cycle after the write edge.
// Backpressure: caller must only push when not full or when popping in the same cycle.
// Ports: clk/rst_n, push/pop/flush controls, din write data, head/count/full/empty status.
module ifetch_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int             PW       = $clog2(DEPTH);
   localparam int             CW       = PW + 1;
   localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Storage carries no reset: only entries below count are ever observed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

endmodule

// File: rtl/ifetch_ctrl.sv
// Purpose: instruction-fetch sequencer: owns fetch PC, prefetches into a tagged queue, handles redirect/halt.
// Latency: word requested in cycle N is queued at the edge ending N and offered to decode in N+1.
// Backpressure: decode stalls via instr_rdy; fetch issues only while the queue has room or is popping.
// Ports: clk, rst_n (async active-low), bus = ifetch_if.master (memory bus, decode handshake, redirect, status).
module ifetch_ctrl
   import ifetch_pkg::*;
#(
   parameter int             DEPTH    = 4,
   parameter int             AW       = IF_AW,
   parameter int             DW       = IF_DW,
   parameter logic [AW-1:0]  RESET_PC = AW'(IF_RESET_PC),
   parameter logic [3:0]     HLT_OP   = IF_HLT_OP
) (
   input  logic     clk,
   input  logic     rst_n,
   ifetch_if.master bus
);

   localparam logic [0:0] RUN  = ST_RUN;
   localparam logic [0:0] HALT = ST_HALT;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [DW-1:0] instr;
   } q_entry_t;

   logic [AW-1:0]          pc_q;
   logic [0:0]             state_q;
   logic                   started_q;
   logic                   pop;
   logic                   issue;
   logic                   hlt_hit;
   logic                   full;
   logic                   empty;
   logic [$clog2(DEPTH):0] count;
   q_entry_t               push_ent;
   q_entry_t               head_ent;

   // Redirect suppresses both sides of the queue; the flush owns that edge.
   assign pop   = ~empty & bus.instr_rdy & ~bus.redirect;
   // started_q holds off the first request until one full cycle after reset release.
   assign issue = started_q & (state_q == RUN) & ~bus.redirect & (~full | pop);
   assign hlt_hit = issue & (bus.im_instr[DW-1 -: 4] == HLT_OP);

   assign push_ent = '{pc: pc_q, instr: bus.im_instr};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         state_q   <= RUN;
         started_q <= 1'b0;
      end else begin
         started_q <= 1'b1;
         if (bus.redirect) begin
            pc_q    <= bus.redirect_pc;
            state_q <= RUN;
         end else if (issue) begin
            pc_q <= pc_q + 1'b1;
            // The halt word itself is queued; only later requests stop.
            if (hlt_hit) state_q <= HALT;
         end
      end
   end

   ifetch_fifo #(
      .DEPTH (DEPTH),
      .W     (AW + DW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (issue),
      .pop   (pop),
      .flush (bus.redirect),
      .din   (push_ent),
      .head  (head_ent),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign bus.im_addr   = pc_q;
   assign bus.im_rd_en  = issue;
   assign bus.instr_out = head_ent.instr;
   assign bus.instr_pc  = head_ent.pc;
   assign bus.instr_vld = ~empty;
   assign bus.halted    = (state_q == HALT);
   assign bus.q_count   = count;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Purpose: self-checking bench for ifetch_ctrl against a queue-based reference model.
// Latency: n/a.
// Backpressure: instr_rdy driven directly and randomly.
module tb_ifetch_ctrl;
   import ifetch_pkg::*;

   localparam int DEPTH = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   ifetch_if #(.DEPTH(DEPTH), .AW(IF_AW), .DW(IF_DW)) bus  ();
   ifetch_if #(.DEPTH(DEPTH), .AW(IF_AW), .DW(IF_DW)) bus2 ();

   ifetch_ctrl #(
      .DEPTH(DEPTH), .AW(IF_AW), .DW(IF_DW), .RESET_PC(16'h0000), .HLT_OP(4'hF)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   ifetch_ctrl #(
      .DEPTH(DEPTH), .AW(IF_AW), .DW(IF_DW), .RESET_PC(16'hFFFE), .HLT_OP(4'hF)
   ) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   logic        hlt_en   = 1'b0;
   logic [15:0] hlt_addr = 16'h0000;

   // Memory image: 0x1xxx everywhere, a single halt word where enabled.
   function automatic logic [15:0] mem_rd(input logic [15:0] a, input logic en, input logic [15:0] ha);
      if (en && a == ha) return 16'hF000 | {4'h0, a[11:0]};
      return {4'h1, a[11:0]};
   endfunction

   always_comb bus.im_instr  = mem_rd(bus.im_addr, hlt_en, hlt_addr);
   always_comb bus2.im_instr = mem_rd(bus2.im_addr, 1'b0, 16'h0000);

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference model state
   entry_t      m_q[$];
   logic [15:0] m_pc;
   bit          m_halt;
   bit          m_started;
   logic [15:0] m2_pc;
   bit          m2_started;
   bit          chk2_en = 1'b0;

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_vld",    32'(bus.instr_vld), 32'd0);
      chk("rst_qcount", 32'(bus.q_count),   32'd0);
      chk("rst_halted", 32'(bus.halted),    32'd0);
      chk("rst_rd_en",  32'(bus.im_rd_en),  32'd0);
      chk("rst_addr",   32'(bus.im_addr),   32'h0000);
      m_q.delete();
      m_pc       = 16'h0000;
      m_halt     = 1'b0;
      m_started  = 1'b0;
      m2_pc      = 16'hFFFE;
      m2_started = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // One clock cycle: apply inputs, compare at the falling edge, advance model at the rising edge.
   task automatic step(input bit rdy, input bit rd, input logic [15:0] rpc);
      bit          exp_issue;
      logic [15:0] w;
      entry_t      e;
      bus.instr_rdy   = rdy;
      bus.redirect    = rd;
      bus.redirect_pc = rpc;
      @(negedge clk);
      chk("instr_vld", 32'(bus.instr_vld), 32'(m_q.size() != 0));
      chk("q_count",   32'(bus.q_count),   32'(m_q.size()));
      chk("halted",    32'(bus.halted),    32'(m_halt));
      if (m_q.size() != 0) begin
         chk("instr_pc",  32'(bus.instr_pc),  32'(m_q[0].pc));
         chk("instr_out", 32'(bus.instr_out), 32'(m_q[0].instr));
      end
      exp_issue = m_started && !m_halt && !rd && (m_q.size() < DEPTH || rdy);
      chk("im_rd_en", 32'(bus.im_rd_en), 32'(exp_issue));
      chk("im_addr",  32'(bus.im_addr),  32'(m_pc));
      if (chk2_en) begin
         chk("wrap_rd_en", 32'(bus2.im_rd_en), 32'(m2_started));
         chk("wrap_addr",  32'(bus2.im_addr),  32'(m2_pc));
      end
      @(posedge clk);
      if (rd) begin
         m_q.delete();
         m_pc   = rpc;
         m_halt = 1'b0;
      end else begin
         if (rdy && m_q.size() != 0) void'(m_q.pop_front());
         if (exp_issue) begin
            w        = mem_rd(m_pc, hlt_en, hlt_addr);
            e.pc     = m_pc;
            e.instr  = w;
            m_q.push_back(e);
            m_pc     = m_pc + 16'd1;
            if (w[15:12] == IF_HLT_OP) m_halt = 1'b1;
         end
      end
      if (m2_started) m2_pc = m2_pc + 16'd1;
      m2_started = 1'b1;
      m_started  = 1'b1;
      #1;
   endtask

   initial begin
      bus.instr_rdy    = 1'b0;
      bus.redirect     = 1'b0;
      bus.redirect_pc  = 16'h0000;
      bus2.instr_rdy   = 1'b1;
      bus2.redirect    = 1'b0;
      bus2.redirect_pc = 16'h0000;
      #2;

      // Streaming with decode always ready; second instance checks PC wrap from FFFE.
      chk2_en = 1'b1;
      do_reset();
      repeat (8) step(1'b1, 1'b0, 16'h0000);
      chk2_en = 1'b0;

      // Stalled decode fills the queue, then pop+issue on the same cycle, then redirect.
      do_reset();
      repeat (6) step(1'b0, 1'b0, 16'h0000);
      chk("full_count", 32'(bus.q_count), 32'd4);
      repeat (5) step(1'b1, 1'b0, 16'h0000);
      step(1'b1, 1'b1, 16'h0040);
      repeat (4) step(1'b1, 1'b0, 16'h0000);

      // Halt word at address 3: stop, drain, resume on redirect.
      hlt_en   = 1'b1;
      hlt_addr = 16'h0003;
      do_reset();
      repeat (6) step(1'b0, 1'b0, 16'h0000);
      repeat (6) step(1'b1, 1'b0, 16'h0000);
      step(1'b1, 1'b1, 16'h0010);
      repeat (5) step(1'b1, 1'b0, 16'h0000);

      // Reset pulse while halted with three entries queued.
      hlt_addr = 16'h0002;
      do_reset();
      repeat (5) step(1'b0, 1'b0, 16'h0000);
      chk("pre_rst_count",  32'(bus.q_count), 32'd3);
      chk("pre_rst_halted", 32'(bus.halted),  32'd1);
      do_reset();
      repeat (5) step(1'b1, 1'b0, 16'h0000);

      // Random traffic: stalls, redirects (including back-to-back), halts.
      hlt_addr = 16'h0018;
      do_reset();
      repeat (400) begin
         step($urandom_range(0, 3) != 0,
              $urandom_range(0, 15) == 0,
              16'($urandom_range(0, 31)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
